// File: rtl/can_codec_pkg.sv
// Shared CAN codec definitions: widths, FSM states and the signal field descriptor.
package can_codec_pkg;

  localparam int FRAC_BITS = 16;
  localparam int PAYLOAD_W = 64;
  localparam int ID_W      = 11;
  localparam int DLC_W     = 4;
  localparam int DIFF_W    = 33;
  localparam int SCALE_W   = 24;
  localparam int PROD_W    = 58;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_CALC   = 2'd1,
    ST_PACK   = 2'd2,
    ST_EMIT   = 2'd3
  } state_e;

  typedef struct packed {
    logic [5:0] start;
    logic [5:0] len;
    logic       is_signed;
  } sig_desc_t;

  // A field is unusable when it is empty, wider than 32 bits, or runs past bit 63.
  function automatic logic desc_illegal(input sig_desc_t d);
    return (d.len == 6'd0) || (d.len > 6'd32) ||
           (({1'b0, d.start} + {1'b0, d.len}) > 7'd64);
  endfunction

endpackage

// File: rtl/can_encode_scale_mul.sv
// Registered 33-bit signed by 24-bit unsigned multiply, one cycle, kept alone so it maps to a DSP.
module can_encode_scale_mul
  import can_codec_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     en_i,
  input  logic signed [DIFF_W-1:0] diff_i,
  input  logic [SCALE_W-1:0]       inv_scale_i,
  output logic signed [PROD_W-1:0] prod_o
);

  logic signed [PROD_W-1:0] prod_q;
  logic signed [PROD_W-1:0] prod_d;

  // The scale is unsigned, so a zero sign bit keeps the product signed-correct.
  assign prod_d = diff_i * $signed({1'b0, inv_scale_i});

  // Capture the product only while the encoder sits in its multiply cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prod_q <= '0;
    end else if (en_i) begin
      prod_q <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/encode_can_message.sv
// CAN signal encoder: inverse-scale, round, saturate and pack signals into a 64-bit Intel-order frame.
// Handshakes: a beat/frame transfers on a rising edge where valid and ready are both high;
// valid-side inputs need only be stable in that cycle, and s_valid is ignored while s_ready is low.
module encode_can_message
  import can_codec_pkg::*;
#(
  parameter int FRAC_BITS = can_codec_pkg::FRAC_BITS,
  parameter int PAYLOAD_W = can_codec_pkg::PAYLOAD_W
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_value,
  input  logic [31:0]          s_offset,
  input  logic [23:0]          s_inv_scale,
  input  logic [5:0]           s_start,
  input  logic [5:0]           s_len,
  input  logic                 s_is_signed,
  input  logic                 s_last,
  input  logic [ID_W-1:0]      s_can_id,
  input  logic [DLC_W-1:0]     s_dlc,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ID_W-1:0]      m_can_id,
  output logic [DLC_W-1:0]     m_dlc,
  output logic [PAYLOAD_W-1:0] m_data,
  output logic                 m_sat,
  output logic                 m_err,
  output state_e               dbg_state
);

  localparam int RAW_W = PROD_W - FRAC_BITS;
  localparam logic signed [PROD_W-1:0] HALF_LSB = PROD_W'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [RAW_W-1:0]  RAW_ONE  = RAW_W'(1);

  state_e                   state_q, state_d;
  logic signed [DIFF_W-1:0] diff_q, diff_d;
  logic [SCALE_W-1:0]       inv_q;
  sig_desc_t                desc_q;
  logic                     last_q;
  logic [ID_W-1:0]          id_q;
  logic [DLC_W-1:0]         dlc_q;
  logic [PAYLOAD_W-1:0]     payload_q, payload_d;
  logic                     sat_q, sat_d, err_q, err_d;

  logic                     beat_hs;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] rounded;
  logic signed [RAW_W-1:0]  raw, max_v, min_v, sat_v;
  logic                     over, under, reject;
  logic [PAYLOAD_W-1:0]     mask, field;

  assign beat_hs = s_valid && s_ready;
  assign diff_d  = $signed({s_value[31], s_value}) - $signed({s_offset[31], s_offset});

  // FSM state register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= ST_ACCEPT;
    else           state_q <= state_d;
  end

  // FSM next state: one beat walks ACCEPT -> CALC -> PACK; the last beat then waits in EMIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCEPT: if (beat_hs) state_d = ST_CALC;
      ST_CALC:   state_d = ST_PACK;
      ST_PACK:   state_d = last_q ? ST_EMIT : ST_ACCEPT;
      ST_EMIT:   if (m_ready) state_d = ST_ACCEPT;
      default:   state_d = ST_ACCEPT;
    endcase
  end

  // Capture the beat on handshake; frame ID and DLC come only from the last beat.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      diff_q <= '0;
      inv_q  <= '0;
      desc_q <= '0;
      last_q <= 1'b0;
      id_q   <= '0;
      dlc_q  <= '0;
    end else if (beat_hs) begin
      diff_q <= diff_d;
      inv_q  <= s_inv_scale;
      desc_q <= '{start: s_start, len: s_len, is_signed: s_is_signed};
      last_q <= s_last;
      if (s_last) begin
        id_q  <= s_can_id;
        dlc_q <= s_dlc;
      end
    end
  end

  can_encode_scale_mul u_mul (
    .clk_i       (ap_clk),
    .rst_n_i     (ap_rst_n),
    .en_i        (state_q == ST_CALC),
    .diff_i      (diff_q),
    .inv_scale_i (inv_q),
    .prod_o      (prod)
  );

  // Round half toward +inf, clamp to the field's range, and build the field mask.
  always_comb begin
    rounded = prod + HALF_LSB;
    raw     = RAW_W'(rounded >>> FRAC_BITS);
    if (desc_q.is_signed) begin
      max_v = (RAW_ONE <<< (desc_q.len - 6'd1)) - RAW_ONE;
      min_v = -(RAW_ONE <<< (desc_q.len - 6'd1));
    end else begin
      max_v = (RAW_ONE <<< desc_q.len) - RAW_ONE;
      min_v = '0;
    end
    over   = raw > max_v;
    under  = raw < min_v;
    sat_v  = over ? max_v : (under ? min_v : raw);
    mask   = (PAYLOAD_W'(1) << desc_q.len) - PAYLOAD_W'(1);
    field  = PAYLOAD_W'(sat_v) & mask;
    reject = desc_illegal(desc_q);
  end

  // Payload and sticky flags: insert in PACK (later fields win overlaps), clear when the frame leaves.
  always_comb begin
    payload_d = payload_q;
    sat_d     = sat_q;
    err_d     = err_q;
    case (state_q)
      ST_PACK: begin
        if (reject) begin
          err_d = 1'b1;
        end else begin
          payload_d = (payload_q & ~(mask << desc_q.start)) | (field << desc_q.start);
          if (over || under) sat_d = 1'b1;
        end
      end
      ST_EMIT: begin
        if (m_ready) begin
          payload_d = '0;
          sat_d     = 1'b0;
          err_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Payload and sticky flag registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      payload_q <= '0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      payload_q <= payload_d;
      sat_q     <= sat_d;
      err_q     <= err_d;
    end
  end

  assign s_ready   = (state_q == ST_ACCEPT);
  assign m_valid   = (state_q == ST_EMIT);
  assign m_can_id  = id_q;
  assign m_dlc     = dlc_q;
  assign m_data    = payload_q;
  assign m_sat     = sat_q;
  assign m_err     = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_encode_can_message.sv
// Directed bench for encode_can_message: hand-computed frames checked through immediate assertions.
module tb_encode_can_message;
  import can_codec_pkg::*;

  // Clock and reset
  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic        s_valid = 1'b0, s_ready;
  logic [31:0] s_value = '0, s_offset = '0;
  logic [23:0] s_inv_scale = '0;
  logic [5:0]  s_start = '0, s_len = '0;
  logic        s_is_signed = 1'b0, s_last = 1'b0;
  logic [10:0] s_can_id = '0;
  logic [3:0]  s_dlc = '0;
  logic        m_valid, m_ready = 1'b0;
  logic [10:0] m_can_id;
  logic [3:0]  m_dlc;
  logic [63:0] m_data;
  logic        m_sat, m_err;
  state_e      dbg_state;

  encode_can_message dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_value(s_value), .s_offset(s_offset),
    .s_inv_scale(s_inv_scale), .s_start(s_start), .s_len(s_len), .s_is_signed(s_is_signed),
    .s_last(s_last), .s_can_id(s_can_id), .s_dlc(s_dlc),
    .m_valid(m_valid), .m_ready(m_ready), .m_can_id(m_can_id), .m_dlc(m_dlc),
    .m_data(m_data), .m_sat(m_sat), .m_err(m_err), .dbg_state(dbg_state)
  );

  // Scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Driver: wait (bounded) for s_ready, present one beat for one cycle, then scramble inputs.
  task automatic send_beat(input logic signed [31:0] v, input logic signed [31:0] off,
                           input logic [23:0] inv, input logic [5:0] st, input logic [5:0] ln,
                           input logic sg, input logic lst, input logic [10:0] id,
                           input logic [3:0] dlc);
    int waited = 0;
    while (!s_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("beat_ready", 64'(s_ready), 64'd1);
    s_value = v; s_offset = off; s_inv_scale = inv; s_start = st; s_len = ln;
    s_is_signed = sg; s_last = lst; s_can_id = id; s_dlc = dlc;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    s_value = $urandom; s_offset = $urandom; s_start = 6'($urandom_range(0, 63));
    s_len = 6'($urandom_range(0, 63)); s_last = 1'($urandom_range(0, 1));
    s_can_id = 11'($urandom); s_dlc = 4'($urandom);
  endtask

  // Receiver: wait (bounded) for m_valid, compare against the queue head, consume at once.
  task automatic recv_frame(input string tag, input logic [10:0] id, input logic [3:0] dlc,
                            input logic sat, input logic err);
    logic [63:0] exp_data;
    int waited = 0;
    exp_data = exp_q.pop_front();
    while (!m_valid && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_valid"}, 64'(m_valid), 64'd1);
    check({tag, "_data"},  m_data, exp_data);
    check({tag, "_id"},    64'(m_can_id), 64'(id));
    check({tag, "_dlc"},   64'(m_dlc), 64'(dlc));
    check({tag, "_sat"},   64'(m_sat), 64'(sat));
    check({tag, "_err"},   64'(m_err), 64'(err));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check({tag, "_sready_after"}, 64'(s_ready), 64'd1);
    check({tag, "_mvalid_after"}, 64'(m_valid), 64'd0);
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data",  m_data, 64'd0);
    check("rst_m_id",    64'(m_can_id), 64'd0);
    check("rst_m_dlc",   64'(m_dlc), 64'd0);
    check("rst_m_sat",   64'(m_sat), 64'd0);
    check("rst_m_err",   64'(m_err), 64'd0);
    tick(); tick();
    ap_rst_n = 1'b1;
    tick();
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_state",   64'(dbg_state), 64'(ST_ACCEPT));

    // 10000 * 1/16 = 625 at start 8, with latency checks
    exp_q.push_back(64'h0000_0000_0002_7100);
    send_beat(10000, 0, 24'h001000, 6'd8, 6'd16, 1'b0, 1'b1, 11'h123, 4'd8);
    check("lat_calc_sready", 64'(s_ready), 64'd0);
    check("lat_calc_mvalid", 64'(m_valid), 64'd0);
    tick();
    check("lat_pack_mvalid", 64'(m_valid), 64'd0);
    tick();
    check("lat_emit_mvalid", 64'(m_valid), 64'd1);
    recv_frame("basic", 11'h123, 4'd8, 1'b0, 1'b0);

    // Unsigned overflow saturates to 0xFF; signed -5 fits in 4 bits as 0xB
    exp_q.push_back(64'h0000_0000_0000_00FF);
    send_beat(2000000, 0, 24'h010000, 6'd0, 6'd8, 1'b0, 1'b1, 11'h0AA, 4'd1);
    recv_frame("sat_hi", 11'h0AA, 4'd1, 1'b1, 1'b0);
    exp_q.push_back(64'h0000_0000_0000_000B);
    send_beat(-5, 0, 24'h010000, 6'd0, 6'd4, 1'b1, 1'b1, 11'h0AB, 4'd1);
    recv_frame("signed_fit", 11'h0AB, 4'd1, 1'b0, 1'b0);

    // Rounding half toward +inf: 1.5 -> 2, -1.5 -> -1
    exp_q.push_back(64'h0000_0000_0000_0002);
    send_beat(3, 0, 24'h008000, 6'd0, 6'd8, 1'b1, 1'b1, 11'h010, 4'd1);
    recv_frame("round_pos", 11'h010, 4'd1, 1'b0, 1'b0);
    exp_q.push_back(64'h0000_0000_0000_00FF);
    send_beat(-3, 0, 24'h008000, 6'd0, 6'd8, 1'b1, 1'b1, 11'h011, 4'd1);
    recv_frame("round_neg", 11'h011, 4'd1, 1'b0, 1'b0);

    // Offset subtraction; negative into an unsigned field clamps to 0
    exp_q.push_back(64'h0000_0000_0000_003C);
    send_beat(100, 40, 24'h010000, 6'd0, 6'd8, 1'b0, 1'b1, 11'h020, 4'd2);
    recv_frame("offset", 11'h020, 4'd2, 1'b0, 1'b0);
    exp_q.push_back(64'h0000_0000_0000_0000);
    send_beat(5, 10, 24'h010000, 6'd0, 6'd8, 1'b0, 1'b1, 11'h021, 4'd2);
    recv_frame("sat_lo", 11'h021, 4'd2, 1'b1, 1'b0);

    // 32-bit signed field at the top of the payload
    exp_q.push_back(64'hFFFF_FFFF_0000_0000);
    send_beat(-1, 0, 24'h010000, 6'd32, 6'd32, 1'b1, 1'b1, 11'h030, 4'd8);
    recv_frame("len32", 11'h030, 4'd8, 1'b0, 1'b0);

    // Three signals into one frame
    exp_q.push_back(64'h0300_0000_0002_0001);
    send_beat(1, 0, 24'h010000, 6'd0,  6'd8, 1'b0, 1'b0, 11'h7FF, 4'd0);
    send_beat(2, 0, 24'h010000, 6'd16, 6'd8, 1'b0, 1'b0, 11'h7FF, 4'd0);
    send_beat(3, 0, 24'h010000, 6'd56, 6'd8, 1'b0, 1'b1, 11'h456, 4'd8);
    recv_frame("three", 11'h456, 4'd8, 1'b0, 1'b0);

    // Field past bit 63 is rejected and leaves the payload alone
    exp_q.push_back(64'h0000_0000_0000_0005);
    send_beat(5, 0, 24'h010000, 6'd0,  6'd8, 1'b0, 1'b0, 11'h000, 4'd0);
    send_beat(9, 0, 24'h010000, 6'd60, 6'd8, 1'b0, 1'b1, 11'h222, 4'd4);
    recv_frame("reject", 11'h222, 4'd4, 1'b0, 1'b1);

    // Backpressure: outputs hold for 10 cycles, then the next frame starts clean
    send_beat(300, 0, 24'h010000, 6'd0, 6'd8, 1'b0, 1'b1, 11'h7AB, 4'd3);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      check("hold_valid",  64'(m_valid), 64'd1);
      check("hold_data",   m_data, 64'h0000_0000_0000_00FF);
      check("hold_id",     64'(m_can_id), 64'h7AB);
      check("hold_sat",    64'(m_sat), 64'd1);
      check("hold_sready", 64'(s_ready), 64'd0);
      tick();
    end
    exp_q.push_back(64'h0000_0000_0000_00FF);
    recv_frame("hold", 11'h7AB, 4'd3, 1'b1, 1'b0);
    exp_q.push_back(64'h0000_0000_0000_0001);
    send_beat(1, 0, 24'h010000, 6'd0, 6'd8, 1'b0, 1'b1, 11'h001, 4'd1);
    recv_frame("after_hold", 11'h001, 4'd1, 1'b0, 1'b0);

    // Reset during PACK of the second signal discards the partial frame
    send_beat(17, 0, 24'h010000, 6'd0, 6'd8, 1'b0, 1'b0, 11'h000, 4'd0);
    send_beat(34, 0, 24'h010000, 6'd8, 6'd8, 1'b0, 1'b0, 11'h000, 4'd0);
    tick();
    check("pre_rst_state", 64'(dbg_state), 64'(ST_PACK));
    ap_rst_n = 1'b0;
    #1;
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_m_data",  m_data, 64'd0);
    check("midrst_m_id",    64'(m_can_id), 64'd0);
    check("midrst_m_dlc",   64'(m_dlc), 64'd0);
    check("midrst_state",   64'(dbg_state), 64'(ST_ACCEPT));
    tick();
    ap_rst_n = 1'b1;
    tick();
    check("midrst_sready", 64'(s_ready), 64'd1);
    exp_q.push_back(64'h0000_0007_0000_0000);
    send_beat(7, 0, 24'h010000, 6'd32, 6'd8, 1'b0, 1'b1, 11'h100, 4'd2);
    recv_frame("post_rst", 11'h100, 4'd2, 1'b0, 1'b0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
